// File: rtl/vga_line_fetch_if.sv
// -----------------------------------------------------------------------------
// vga_line_fetch_if
// Framebuffer read port used by the line-fetch stage.
//
// Handshake: the master raises mem_req with mem_addr and holds mem_addr stable
// until a cycle in which the slave drives mem_ack high. In that same cycle
// mem_data carries the addressed pixel and the transfer is complete. Acks seen
// while mem_req is low carry no meaning and are dropped by the master.
//
// Signals:
//   mem_req   master -> slave  read request
//   mem_addr  master -> slave  pixel address (one RGB332 pixel per address)
//   mem_ack   slave  -> master request accepted, mem_data valid this cycle
//   mem_data  slave  -> master RGB332 pixel
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 11
`endif

interface vga_line_fetch_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [7:0]            mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/vga_line_fetch.sv
// -----------------------------------------------------------------------------
// vga_line_fetch
// Pixel-pipeline stage behind the VGA timing generator. Each scan line is
// prefetched from the framebuffer into one bank of a ping-pong line buffer
// (bank = line[0]) while the other bank is being displayed. Pixels come out
// PIPE_LATENCY cycles after their position, with sync and DE delayed to match.
//
// Ports:
//   pixel_clock, reset_n      clock, asynchronous active-low reset
//   h_position, v_position    current column / row from the timing generator
//   visible_area              high inside the active picture
//   hsync_in, vsync_in        syncs, polarity passed through
//   mem                       framebuffer read port (master side)
//   rgb                       RGB332 output pixel (0 outside the picture)
//   hsync_out, vsync_out      syncs delayed to line up with rgb
//   de_out                    visible_area delayed to line up with rgb
//   underrun                  sticky: a fetch was cut short or an unfilled
//                             bank was displayed
//   dbg_fetching              FSM state (1 = FETCH)
//   dbg_bank_valid            per-bank "line fully loaded" flags
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 11
`endif

module vga_line_fetch #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 800,
    parameter int ADDR_WIDTH = 20,
    localparam int PIPE_LATENCY = 2
) (
    input  logic                       pixel_clock,
    input  logic                       reset_n,
    input  logic [`POSITION_WIDTH-1:0] h_position,
    input  logic [`POSITION_WIDTH-1:0] v_position,
    input  logic                       visible_area,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    vga_line_fetch_if.master           mem,
    output logic [7:0]                 rgb,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic                       de_out,
    output logic                       underrun,
    output logic                       dbg_fetching,
    output logic [1:0]                 dbg_bank_valid
);
    localparam int PW = `POSITION_WIDTH;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0]         H_TRIG      = PW'(WIDTH);
    localparam logic [PW-1:0]         V_LIMIT     = PW'(HEIGHT);
    localparam logic [PW-1:0]         V_LAST      = PW'(HEIGHT - 1);
    localparam logic [XW-1:0]         X_LAST      = XW'(WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        state;
    logic          init_pending;   // forces a line-0 fetch on the first clock after reset
    logic [XW-1:0] x_cnt;
    logic          tgt_bank;
    logic [1:0]    bank_valid;

    // ------------------------------------------------------------------
    // Fetch trigger and target line. The line base multiply only happens
    // here, once per line; per-pixel addressing is a plain increment.
    // ------------------------------------------------------------------
    logic                  trigger;
    logic                  start;
    logic                  abandon;
    logic                  accept;
    logic                  new_bank;
    logic [ADDR_WIDTH-1:0] new_line;
    logic [ADDR_WIDTH-1:0] new_base;

    always_comb begin
        trigger  = (h_position == H_TRIG) && (v_position < V_LIMIT);
        start    = trigger || init_pending;
        new_line = '0;
        if (trigger && (v_position != V_LAST)) begin
            new_line = ADDR_WIDTH'(v_position) + ADDR_WIDTH'(1);
        end
        new_bank = new_line[0];
        new_base = new_line * LINE_STRIDE;
        // A trigger landing mid-fetch restarts the fetch; the old one is lost.
        abandon  = start && (state == FETCH);
        // A restart takes priority over an ack arriving in the same cycle.
        accept   = (state == FETCH) && mem.mem_ack && !start;
    end

    // ------------------------------------------------------------------
    // Fetch FSM. mem_req / mem_addr are registered, so mem_addr only moves
    // on an accepted beat and is stable across stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            init_pending <= 1'b1;
            x_cnt        <= '0;
            tgt_bank     <= 1'b0;
            bank_valid   <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            init_pending <= 1'b0;
            if (start) begin
                state                <= FETCH;
                mem.mem_req          <= 1'b1;
                mem.mem_addr         <= new_base;
                x_cnt                <= '0;
                tgt_bank             <= new_bank;
                bank_valid[new_bank] <= 1'b0;
            end else if (accept) begin
                if (x_cnt == X_LAST) begin
                    state                <= IDLE;
                    mem.mem_req          <= 1'b0;
                    bank_valid[tgt_bank] <= 1'b1;
                end else begin
                    x_cnt        <= x_cnt + XW'(1);
                    mem.mem_addr <= mem.mem_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: one write port (fetch), one synchronous read port
    // (display). The fetch bank never equals the displayed bank while
    // visible, so there is no read/write collision to resolve.
    // ------------------------------------------------------------------
    logic [7:0] line_ram [2][WIDTH];
    logic [7:0] rd_data;

    always_ff @(posedge pixel_clock) begin
        if (accept) begin
            line_ram[tgt_bank][x_cnt] <= mem.mem_data;
        end
        if (visible_area) begin
            rd_data <= line_ram[v_position[0]][h_position[XW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Display pipeline. Stage 0 captures the RAM read and the bank's valid
    // flag; stage 1 forms rgb. Sync/DE ride in shift registers of the same
    // depth so everything leaves together.
    // ------------------------------------------------------------------
    logic [PIPE_LATENCY-1:0] hs_pipe;
    logic [PIPE_LATENCY-1:0] vs_pipe;
    logic [PIPE_LATENCY-1:0] de_pipe;
    logic                    valid_s1;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            de_pipe  <= '0;
            valid_s1 <= 1'b0;
            rgb      <= 8'h00;
            underrun <= 1'b0;
        end else begin
            hs_pipe  <= {hs_pipe[PIPE_LATENCY-2:0], hsync_in};
            vs_pipe  <= {vs_pipe[PIPE_LATENCY-2:0], vsync_in};
            de_pipe  <= {de_pipe[PIPE_LATENCY-2:0], visible_area};
            valid_s1 <= bank_valid[v_position[0]];
            rgb      <= (de_pipe[0] && valid_s1) ? rd_data : 8'h00;
            if (abandon || (de_pipe[0] && !valid_s1)) begin
                underrun <= 1'b1;
            end
        end
    end

    assign hsync_out      = hs_pipe[PIPE_LATENCY-1];
    assign vsync_out      = vs_pipe[PIPE_LATENCY-1];
    assign de_out         = de_pipe[PIPE_LATENCY-1];
    assign dbg_fetching   = (state == FETCH);
    assign dbg_bank_valid = bank_valid;

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Pixel-pipeline stage directly downstream of the VGA timing generator, in the pixel_clock domain.
- Consumes h_position, v_position, visible_area and the two sync outputs.
- Prefetches each scan line from framebuffer memory into a ping-pong line buffer over a req/ack read port.
- Emits 8-bit RGB332 pixels with hsync, vsync and data-enable delayed to stay aligned with the pixels.

Parameters:
- WIDTH, 1280: visible pixels per line; same value as the timing generator.
- HEIGHT, 800: visible lines per frame.
- ADDR_WIDTH, 20: framebuffer address width; must satisfy WIDTH*HEIGHT <= 2^ADDR_WIDTH.
- PIPE_LATENCY, 2: fixed position-to-pixel latency in cycles; not user-tunable, exported for sink blocks.

Ports:
- pixel_clock  in  1: pixel clock; all logic runs on its rising edge.
- reset_n  in  1: asynchronous active-low reset.
- h_position  in  `POSITION_WIDTH: current column from the timing generator.
- v_position  in  `POSITION_WIDTH: current row.
- visible_area  in  1: high while h < WIDTH and v < HEIGHT.
- hsync_in  in  1: horizontal sync from the timing generator; polarity passed through unchanged.
- vsync_in  in  1: vertical sync; polarity passed through unchanged.
- mem_req  out  1: read request to the framebuffer.
- mem_addr  out  ADDR_WIDTH: read address; byte address with one pixel per address.
- mem_ack  in  1: request accepted; mem_data is valid in the same cycle.
- mem_data  in  8: RGB332 pixel.
- rgb  out  8: output pixel.
- hsync_out  out  1: hsync_in delayed 2 cycles.
- vsync_out  out  1: vsync_in delayed 2 cycles.
- de_out  out  1: visible_area delayed 2 cycles.
- underrun  out  1: sticky error flag.

Behaviour:
- Reset (async, reset_n=0):
  - rgb, hsync_out, vsync_out, de_out, mem_req and underrun all go to 0.
  - mem_addr goes to 0.
  - Both bank_valid bits are cleared.
  - FSM goes to IDLE.
  - Line-buffer RAM contents are don't-care.
- First fetch after reset: on the first clock after reset_n deasserts, the block issues one fetch of line 0 into bank 0.
- Line buffers: two banks of WIDTH bytes. Bank index = line[0]. Each bank has a bank_valid bit.
- Fetch trigger: the cycle where h_position == WIDTH and v_position < HEIGHT.
  - target = v_position+1 when v_position < HEIGHT-1.
  - target = 0 when v_position == HEIGHT-1.
  - No triggers occur during vertical blanking.
- On trigger:
  - bank_valid[target[0]] <= 0.
  - x_cnt <= 0.
  - FSM -> FETCH.
  - If the FSM was already in FETCH, that fetch is abandoned, underrun <= 1, and the new fetch starts (same-cycle restart; mem_req stays high).
- FSM states: IDLE and FETCH.
  - IDLE: mem_req = 0; leaves only on a trigger.
  - FETCH: mem_req = 1, mem_addr = target*WIDTH + x_cnt.
- Address width: target*WIDTH is computed at trigger time and registered as the line base. No multiplier sits in the per-pixel path.
- Request handshake:
  - mem_addr must stay stable while mem_req=1 and mem_ack=0.
  - On mem_ack: write mem_data to bank[target[0]][x_cnt], then x_cnt++.
  - If x_cnt == WIDTH-1 at ack, set bank_valid[target[0]] <= 1 and go to IDLE. mem_req drops the next cycle.
  - mem_ack while mem_req=0 is ignored.
  - Back-to-back acks give 1 pixel per cycle.
- Display read, cycle 0: if visible_area, read bank[v_position[0]] at address h_position and latch bank_valid of that bank.
- Display read, cycle 1: the synchronous RAM returns data.
- Display read, cycle 2: rgb is registered.
  - rgb = data when de is high and the latched valid=1.
  - rgb = 0 when de is low.
- Invalid bank read: if the latched valid=0 during visible, rgb = 0 and underrun <= 1.
- Underrun is sticky until reset.
- Sync and DE: hsync_out, vsync_out and de_out are 2-stage shift registers of their inputs, exactly aligned with rgb.
- Collision freedom:
  - The write bank for target v+1 differs from the read bank for line v.
  - For target 0 after line HEIGHT-1, the visible reads of that line have already finished when the trigger fires.
  - Simultaneous same-address read and write therefore cannot occur in visible time, regardless of HEIGHT parity.
- Reset mid-fetch: mem_req drops asynchronously. Memory must discard any outstanding request.

Test Plan:
- WIDTH=8, HEIGHT=4, mem_ack tied high:
  - After reset release, mem_addr steps 0..7 on consecutive cycles.
  - mem_req is high for 8 cycles, then 0.
  - bank_valid[0]=1.
- Same config, mem_data = mem_addr[7:0], two full frames:
  - Every visible (x,y) in frame 2 yields rgb = y*8+x, exactly 2 cycles after the position.
  - de_out matches; underrun stays 0.
- Toggle hsync_in/vsync_in with arbitrary patterns: hsync_out and vsync_out equal the inputs delayed exactly 2 cycles; rgb = 0 whenever de_out=0.
- mem_ack every 4th cycle with a line budget shorter than 4*WIDTH:
  - The next trigger abandons the fetch and underrun=1.
  - The affected line displays rgb=0.
  - The following line's fetch addresses restart at base+0.
- Assert reset_n low while mem_req=1 at x_cnt=3: mem_req=0 with no clock edge; after release, the fetch restarts at address 0 and underrun=0.
- Trigger at v=HEIGHT-1 (v=3): fetch addresses 0..7 go into bank 0, and line 0 of the next frame displays the new data.
